// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin codes,
// denomination values, error codes and the slot price function.
// Pure declarations; no latency or backpressure of its own.
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CREDIT,
      ST_LOOKUP,
      ST_DISPENSE,
      ST_CHANGE
   } state_t;

   localparam logic [3:0] MONEY_500  = 4'b0001;
   localparam logic [3:0] MONEY_1000 = 4'b0010;
   localparam logic [3:0] MONEY_2000 = 4'b0100;
   localparam logic [3:0] MONEY_5000 = 4'b1000;

   localparam logic [15:0] VALUE_500  = 16'd500;
   localparam logic [15:0] VALUE_1000 = 16'd1000;
   localparam logic [15:0] VALUE_2000 = 16'd2000;
   localparam logic [15:0] VALUE_5000 = 16'd5000;

   localparam logic [3:0] ERR_NONE    = 4'b0000;
   localparam logic [3:0] ERR_COIN    = 4'b0001;
   localparam logic [3:0] ERR_FUNDS   = 4'b0010;
   localparam logic [3:0] ERR_SOLDOUT = 4'b0100;
   localparam logic [3:0] ERR_BUSY    = 4'b1000;

   // Slot n costs 500*(n+1): 500 for slot 0 up to 4000 for slot 7.
   function automatic logic [15:0] price_of(input logic [2:0] slot);
      return VALUE_500 * ({13'd0, slot} + 16'd1);
   endfunction

   // Value of a coin code; zero flags an invalid (non one-hot) code.
   function automatic logic [15:0] coin_value(input logic [3:0] money);
      case (money)
         MONEY_500:  return VALUE_500;
         MONEY_1000: return VALUE_1000;
         MONEY_2000: return VALUE_2000;
         MONEY_5000: return VALUE_5000;
         default:    return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_if.sv
// Strobe/status bundle between a vending front panel (master) and the controller (slave).
// Wires only; no latency.
// No backpressure: requests are one-cycle strobes, the slave reports busy.
interface vend_if;
   logic        coin_valid;
   logic [3:0]  money_type;
   logic        select_valid;
   logic [2:0]  address;
   logic        cancel;
   logic        restock;
   logic [15:0] credit;
   logic        busy;
   logic        dispense_valid;
   logic [2:0]  dispense_addr;
   logic        change_valid;
   logic [15:0] change_amount;
   logic [3:0]  error;

   modport master (
      output coin_valid, money_type, select_valid, address, cancel, restock,
      input  credit, busy, dispense_valid, dispense_addr, change_valid, change_amount, error
   );

   modport slave (
      input  coin_valid, money_type, select_valid, address, cancel, restock,
      output credit, busy, dispense_valid, dispense_addr, change_valid, change_amount, error
   );
endinterface

// File: rtl/vend_price_rom.sv
// Slot address to 16-bit price lookup.
// Purely combinational, zero cycles.
// No handshake; output follows the address.
module vend_price_rom
   import vend_pkg::*;
(
   input  logic [2:0]  address,
   output logic [15:0] price
);

   assign price = price_of(address);

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin credit, price lookup, vend and refund sequencing.
// Latency: coin->credit 1 cycle, select->dispense_valid 2 cycles, change 1 cycle after dispense.
// No backpressure: strobes seen while busy are dropped with an ERR_BUSY pulse. Macro VEND_STOCK_EN adds stock.
module vend_controller
   import vend_pkg::*;
#(
   parameter int MAX_CREDIT = 20000,
   parameter int STOCK_INIT = 8
) (
   input  logic  clock,
   input  logic  reset,
   vend_if.slave bus
);

   state_t      state, state_nxt;
   logic [15:0] credit_q, credit_nxt;
   logic [2:0]  slot_q, slot_nxt;
   logic [15:0] price_q, price_nxt;
   logic [3:0]  error_q, error_nxt;
   logic [15:0] rom_price;
   logic [15:0] coin_val;
   logic [16:0] coin_sum;
   logic        soldout;
   logic        idle_like;
   logic        busy_strobe;

   vend_price_rom u_price_rom (
      .address (bus.address),
      .price   (rom_price)
   );

   assign coin_val    = coin_value(bus.money_type);
   assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
   assign idle_like   = (state == ST_IDLE) || (state == ST_CREDIT);
   assign busy_strobe = bus.coin_valid || bus.select_valid;

`ifdef VEND_STOCK_EN
   localparam logic [7:0] STOCK_RELOAD = 8'(STOCK_INIT);
   logic [7:0] stock_q [8];

   // Stock counts: reload on reset or restock while not busy, count down on each vend.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) stock_q[i] <= STOCK_RELOAD;
      end else if (bus.restock && idle_like) begin
         for (int i = 0; i < 8; i++) stock_q[i] <= STOCK_RELOAD;
      end else if (state == ST_DISPENSE) begin
         stock_q[slot_q] <= stock_q[slot_q] - 8'd1;
      end
   end

   assign soldout = (stock_q[slot_q] == 8'd0);
`else
   logic unused_cfg;
   assign unused_cfg = ^{bus.restock, 8'(STOCK_INIT)};
   assign soldout    = 1'b0;
`endif

   // Next-state and datapath updates. A failed lookup's error outranks a
   // simultaneous ERR_BUSY because the error output is one-hot.
   always_comb begin
      state_nxt  = state;
      credit_nxt = credit_q;
      slot_nxt   = slot_q;
      price_nxt  = price_q;
      error_nxt  = ERR_NONE;
      case (state)
         ST_IDLE, ST_CREDIT: begin
            if (bus.cancel) begin
               if (state == ST_CREDIT) state_nxt = ST_CHANGE;
               if (bus.coin_valid) error_nxt = ERR_BUSY;
            end else if (bus.select_valid) begin
               slot_nxt  = bus.address;
               price_nxt = rom_price;
               state_nxt = ST_LOOKUP;
               if (bus.coin_valid) error_nxt = ERR_BUSY;
            end else if (bus.coin_valid) begin
               if (coin_val == 16'd0 || coin_sum > 17'(MAX_CREDIT)) begin
                  error_nxt = ERR_COIN;
               end else begin
                  credit_nxt = coin_sum[15:0];
                  state_nxt  = ST_CREDIT;
               end
            end
         end
         ST_LOOKUP: begin
            if (busy_strobe) error_nxt = ERR_BUSY;
            if (soldout || credit_q < price_q) begin
               error_nxt = soldout ? ERR_SOLDOUT : ERR_FUNDS;
               state_nxt = (credit_q == 16'd0) ? ST_IDLE : ST_CREDIT;
            end else begin
               state_nxt = ST_DISPENSE;
            end
         end
         ST_DISPENSE: begin
            if (busy_strobe) error_nxt = ERR_BUSY;
            credit_nxt = credit_q - price_q;
            state_nxt  = (credit_q == price_q) ? ST_IDLE : ST_CHANGE;
         end
         ST_CHANGE: begin
            if (busy_strobe) error_nxt = ERR_BUSY;
            credit_nxt = 16'd0;
            state_nxt  = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Credit, latched selection and the registered one-cycle error pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         credit_q <= 16'd0;
         slot_q   <= 3'd0;
         price_q  <= 16'd0;
         error_q  <= ERR_NONE;
      end else begin
         credit_q <= credit_nxt;
         slot_q   <= slot_nxt;
         price_q  <= price_nxt;
         error_q  <= error_nxt;
      end
   end

   assign bus.credit         = credit_q;
   assign bus.busy           = (state == ST_LOOKUP) || (state == ST_DISPENSE) || (state == ST_CHANGE);
   assign bus.dispense_valid = (state == ST_DISPENSE);
   assign bus.dispense_addr  = (state == ST_DISPENSE) ? slot_q : 3'd0;
   assign bus.change_valid   = (state == ST_CHANGE);
   assign bus.change_amount  = (state == ST_CHANGE) ? credit_q : 16'd0;
   assign bus.error          = error_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model queues expected
// output events (kind, value, cycle); a negedge monitor pops and compares them.
// Directed scenarios first, then randomized coins/selects/cancels/restocks.
module tb_vend_controller;

   localparam int MAX_CREDIT = 20000;
   localparam int STOCK_INIT = 1;

   localparam int EV_ERR  = 0;
   localparam int EV_DISP = 1;
   localparam int EV_CHG  = 2;

   localparam int E_COIN  = 1;
   localparam int E_FUNDS = 2;
   localparam int E_SOLD  = 4;
   localparam int E_BUSY  = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;

   vend_if vbus ();

   vend_controller #(
      .MAX_CREDIT (MAX_CREDIT),
      .STOCK_INIT (STOCK_INIT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (vbus)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int kind;
      int val;
      int at;
   } ev_t;

   ev_t expq[$];
   int  m_credit = 0;
   int  m_stock [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Keep the queue ordered by cycle, then by the monitor's per-cycle order.
   function automatic void push_ev(input int kind, input int val, input int at);
      ev_t e;
      int  idx;
      e.kind = kind;
      e.val  = val;
      e.at   = at;
      idx    = expq.size();
      while (idx > 0 && (expq[idx-1].at * 4 + expq[idx-1].kind) > (at * 4 + kind)) idx--;
      expq.insert(idx, e);
   endfunction

   task automatic take(input int kind, input int val);
      ev_t e;
      checks++;
      if (expq.size() == 0) begin
         errors++;
         $display("FAIL event: unexpected kind=%0d value=%0d at cycle %0d, none expected", kind, val, cyc);
      end else begin
         e = expq.pop_front();
         if (e.kind != kind || e.val != val || e.at != cyc) begin
            errors++;
            $display("FAIL event: got kind=%0d value=%0d cycle=%0d, expected kind=%0d value=%0d cycle=%0d",
                     kind, val, cyc, e.kind, e.val, e.at);
         end
      end
   endtask

   // Monitor: errors, then dispense, then change within one cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (vbus.error != 4'd0) take(EV_ERR, int'(vbus.error));
         if (vbus.dispense_valid) take(EV_DISP, int'(vbus.dispense_addr));
         else chk("dispense_addr while idle", int'(vbus.dispense_addr), 0);
         if (vbus.change_valid) take(EV_CHG, int'(vbus.change_amount));
         else chk("change_amount while idle", int'(vbus.change_amount), 0);
      end
   end

   function automatic int coin_val(input logic [3:0] mt);
      case (mt)
         4'b0001: return 500;
         4'b0010: return 1000;
         4'b0100: return 2000;
         4'b1000: return 5000;
         default: return 0;
      endcase
   endfunction

   task automatic tick();
      @(negedge clock);
      vbus.coin_valid   = 1'b0;
      vbus.select_valid = 1'b0;
      vbus.cancel       = 1'b0;
      vbus.restock      = 1'b0;
   endtask

   task automatic check_quiet(input string name);
      chk({name, " credit"}, int'(vbus.credit), m_credit);
      chk({name, " busy"}, int'(vbus.busy), 0);
   endtask

   task automatic do_coin(input logic [3:0] mt);
      int v = coin_val(mt);
      if (v == 0 || m_credit + v > MAX_CREDIT) push_ev(EV_ERR, E_COIN, cyc + 1);
      else m_credit += v;
      vbus.coin_valid = 1'b1;
      vbus.money_type = mt;
      tick();
   endtask

   // Purchase; optionally a coin in the same cycle, and a coin/select at
   // busy_off cycles later (only injected while the purchase keeps the unit busy).
   task automatic do_select(input int slot, input bit with_coin, input int busy_off, input bit busy_sel);
      int k     = cyc;
      int price = 500 * (slot + 1);
      int rem   = 0;
      bit ok    = 1'b0;
      bit sold  = 1'b0;
`ifdef VEND_STOCK_EN
      sold = (m_stock[slot] == 0);
`endif
      if (with_coin) push_ev(EV_ERR, E_BUSY, k + 1);
      if (sold) begin
         push_ev(EV_ERR, E_SOLD, k + 2);
      end else if (m_credit < price) begin
         push_ev(EV_ERR, E_FUNDS, k + 2);
      end else begin
         ok  = 1'b1;
         rem = m_credit - price;
         push_ev(EV_DISP, slot, k + 2);
         if (rem > 0) push_ev(EV_CHG, rem, k + 3);
         m_credit = 0;
`ifdef VEND_STOCK_EN
         m_stock[slot]--;
`endif
      end
      if (ok && busy_off >= 1 && busy_off <= ((rem > 0) ? 3 : 2)) push_ev(EV_ERR, E_BUSY, k + busy_off + 1);
      else busy_off = 0;
      vbus.select_valid = 1'b1;
      vbus.address      = 3'(slot);
      if (with_coin) begin
         vbus.coin_valid = 1'b1;
         vbus.money_type = 4'b0001;
      end
      tick();
      for (int i = 1; i <= 3; i++) begin
         if (i == busy_off) begin
            if (busy_sel) begin
               vbus.select_valid = 1'b1;
               vbus.address      = 3'($urandom_range(0, 7));
            end else begin
               vbus.coin_valid = 1'b1;
               vbus.money_type = 4'b0010;
            end
         end
         tick();
      end
   endtask

   task automatic do_cancel(input bit with_coin);
      int k = cyc;
      if (with_coin) push_ev(EV_ERR, E_BUSY, k + 1);
      if (m_credit > 0) push_ev(EV_CHG, m_credit, k + 1);
      m_credit    = 0;
      vbus.cancel = 1'b1;
      if (with_coin) begin
         vbus.coin_valid = 1'b1;
         vbus.money_type = 4'b0100;
      end
      tick();
      tick();
   endtask

   task automatic do_restock();
      vbus.restock = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) m_stock[i] = STOCK_INIT;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, " credit"}, int'(vbus.credit), 0);
      chk({name, " busy"}, int'(vbus.busy), 0);
      chk({name, " dispense_valid"}, int'(vbus.dispense_valid), 0);
      chk({name, " dispense_addr"}, int'(vbus.dispense_addr), 0);
      chk({name, " change_valid"}, int'(vbus.change_valid), 0);
      chk({name, " change_amount"}, int'(vbus.change_amount), 0);
      chk({name, " error"}, int'(vbus.error), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int r;
      vbus.coin_valid   = 1'b0;
      vbus.money_type   = 4'b0000;
      vbus.select_valid = 1'b0;
      vbus.address      = 3'd0;
      vbus.cancel       = 1'b0;
      vbus.restock      = 1'b0;
      for (int i = 0; i < 8; i++) m_stock[i] = STOCK_INIT;

      #1 reset = 1'b1;
      #2 check_reset_outputs("reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Coins of every denomination on consecutive cycles.
      do_coin(4'b0001); chk("credit after 500", int'(vbus.credit), 500);
      do_coin(4'b0010); chk("credit after 1000", int'(vbus.credit), 1500);
      do_coin(4'b0100); chk("credit after 2000", int'(vbus.credit), 3500);
      do_coin(4'b1000); chk("credit after 5000", int'(vbus.credit), 8500);

      // Buy slot 3 from 8500: vend then 6500 change.
      do_select(3, 1'b0, 0, 1'b0);
      check_quiet("after slot3 purchase");

      // Insufficient funds, then cancel refunds.
      do_coin(4'b0010);
      do_select(7, 1'b0, 0, 1'b0);
      chk("credit kept after ERR_FUNDS", int'(vbus.credit), 1000);
      do_cancel(1'b0);
      check_quiet("after cancel");

      // Bad coin code, credit ceiling, coin during lookup.
      do_coin(4'b0011);
      chk("credit after bad code", int'(vbus.credit), 0);
      repeat (3) do_coin(4'b1000);
      repeat (2) do_coin(4'b0100);
      do_coin(4'b0001);
      chk("credit at 19500", int'(vbus.credit), 19500);
      do_coin(4'b0010);
      chk("credit after over-limit coin", int'(vbus.credit), 19500);
      do_coin(4'b0001);
      chk("credit at limit", int'(vbus.credit), 20000);
      do_select(7, 1'b0, 1, 1'b0);
      check_quiet("after busy coin purchase");

`ifdef VEND_STOCK_EN
      do_restock();
      do_coin(4'b0010);
      do_select(0, 1'b0, 0, 1'b0);
      do_coin(4'b0001);
      do_select(0, 1'b0, 0, 1'b0);
      chk("credit kept after ERR_SOLDOUT", int'(vbus.credit), 500);
      do_restock();
      do_select(0, 1'b0, 0, 1'b0);
      check_quiet("after restock purchase");
`endif

      // Reset during DISPENSE aborts with no change pulse.
      do_coin(4'b1000); do_coin(4'b0100); do_coin(4'b0010); do_coin(4'b0001);
      chk("credit before abort", int'(vbus.credit), 8500);
      k = cyc;
      push_ev(EV_DISP, 5, k + 2);
      vbus.select_valid = 1'b1;
      vbus.address      = 3'd5;
      tick();
      tick();
      #2 reset = 1'b1;
      #1 check_reset_outputs("mid-dispense reset");
      m_credit = 0;
      for (int i = 0; i < 8; i++) m_stock[i] = STOCK_INIT;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) tick();
      check_quiet("after abort");

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 40) begin
            if ($urandom_range(0, 9) == 0) do_coin(4'($urandom_range(0, 15)));
            else do_coin(4'(1 << $urandom_range(0, 3)));
            chk("random coin credit", int'(vbus.credit), m_credit);
         end else if (r < 70) begin
            do_select($urandom_range(0, 7), ($urandom_range(0, 5) == 0),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            check_quiet("random select");
         end else if (r < 85) begin
            do_cancel(($urandom_range(0, 3) == 0));
            check_quiet("random cancel");
         end else if (r < 92) begin
`ifdef VEND_STOCK_EN
            do_restock();
`else
            vbus.restock = 1'b1;
            tick();
`endif
            check_quiet("random restock");
         end else begin
            tick();
         end
      end

      repeat (4) tick();
      chk("expected events left over", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter MAX_CREDIT, default 20000: highest credit the controller SHALL accept, in currency units.
REQ-002 Parameter STOCK_INIT, default 8: per-slot stock count loaded at reset and on restock (used only with VEND_STOCK_EN).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 coin_valid  input  1  one-cycle strobe: money_type is valid this cycle.
REQ-006 money_type  input  4  one-hot denomination: 0001=500, 0010=1000, 0100=2000, 1000=5000.
REQ-007 select_valid  input  1  one-cycle strobe: address is a purchase request.
REQ-008 address  input  3  product slot 0-7.
REQ-009 cancel  input  1  one-cycle strobe: refund all credit.
REQ-010 restock  input  1  one-cycle strobe: reload all slot stock (VEND_STOCK_EN only; otherwise ignored).
REQ-011 credit  output  16  current accumulated credit.
REQ-012 busy  output  1  high in LOOKUP, DISPENSE and CHANGE.
REQ-013 dispense_valid / dispense_addr  output  1 / 3  one-cycle vend pulse and the vended slot.
REQ-014 change_valid / change_amount  output  1 / 16  one-cycle refund pulse and the refunded amount.
REQ-015 error  output  4  one-cycle one-hot pulse: 0001 ERR_COIN, 0010 ERR_FUNDS, 0100 ERR_SOLDOUT, 1000 ERR_BUSY; 0000 otherwise.

Function
REQ-016 The controller SHALL use the states IDLE (credit==0), CREDIT (credit>0), LOOKUP, DISPENSE and CHANGE.
REQ-017 The price of slot n SHALL be 500*(n+1) (500 to 4000), computed as a 16-bit unsigned value.
REQ-018 In IDLE/CREDIT, an accepted coin SHALL add its value to credit at the next edge and move to CREDIT.
REQ-019 In IDLE/CREDIT, a coin that is not one-hot, or one that would push credit above MAX_CREDIT, SHALL leave credit unchanged and pulse ERR_COIN.
REQ-020 Input priority in IDLE/CREDIT SHALL be cancel > select_valid > coin_valid; a coin_valid that loses to cancel or select SHALL be dropped and pulse ERR_BUSY.
REQ-021 In CREDIT, cancel SHALL go to CHANGE; in IDLE, cancel SHALL be a no-op with no pulse.
REQ-022 select_valid in IDLE/CREDIT SHALL latch address and the slot price, then go to LOOKUP.
REQ-023 LOOKUP SHALL last exactly one cycle. If credit < price: pulse ERR_FUNDS and return to CREDIT, or to IDLE when credit==0. Otherwise go to DISPENSE.
REQ-024 DISPENSE SHALL last one cycle: dispense_valid=1, dispense_addr=latched slot, credit<=credit-price. Next state is CHANGE if the remainder is >0, else IDLE.
REQ-025 CHANGE SHALL last one cycle: change_valid=1, change_amount=credit. credit<=0, next state IDLE.
REQ-026 dispense_valid SHALL assert exactly 2 cycles after the edge that samples select_valid.
REQ-027 coin_valid, select_valid and cancel sampled while busy=1 SHALL be ignored; coin_valid and select_valid while busy SHALL each pulse ERR_BUSY.
REQ-028 change_amount and dispense_addr SHALL be 0 whenever their valid is low.

Reset
REQ-029 While reset is high, the controller SHALL set: state=IDLE, credit=0, busy=0, dispense_valid=0, dispense_addr=0, change_valid=0, change_amount=0, error=0, and all stock counts=STOCK_INIT.
REQ-030 Reset asserted mid-transaction SHALL abort it with no dispense or change pulse; credit is lost.

Configuration
REQ-031 With VEND_STOCK_EN defined, each slot SHALL hold an 8-bit stock count.
- LOOKUP with stock==0 pulses ERR_SOLDOUT (takes precedence over ERR_FUNDS) and returns to CREDIT/IDLE.
- DISPENSE decrements the slot's count.
- restock in IDLE/CREDIT reloads all counts to STOCK_INIT; restock while busy is ignored.
REQ-032 Without VEND_STOCK_EN, the controller SHALL have no stock storage, SHALL never pulse ERR_SOLDOUT, and restock SHALL be unused.

Structure
REQ-033 Package vend_pkg SHALL hold: the state enum, money_type codes, denomination values, error codes and the price function.
REQ-034 Price lookup SHALL be a separate combinational sub-module, vend_price_rom (address -> 16-bit price).

Verification
REQ-035 Reset; coins 500, 1000, 2000, 5000 on consecutive cycles -> credit = 500, 1500, 3500, 8500; error stays 0.
REQ-036 credit=8500; select slot 3 -> dispense_valid with addr=3 two cycles later, then change_valid with change_amount=6500, credit=0, state IDLE.
REQ-037 credit=1000; select slot 7 -> ERR_FUNDS pulse, credit stays 1000, no dispense; then cancel -> change_amount=1000.
REQ-038 money_type=0011 -> ERR_COIN; credit=19500 plus coin 1000 -> ERR_COIN, credit stays 19500; coin_valid during LOOKUP -> ERR_BUSY, credit unchanged.
REQ-039 VEND_STOCK_EN with STOCK_INIT=1: two purchases of slot 0 at credit 1000 -> first dispenses, second pulses ERR_SOLDOUT with credit 500 retained; restock, then purchase -> dispenses.
REQ-040 Reset asserted during DISPENSE -> all outputs 0 immediately; no change_valid follows.
